// File: rtl/swap_pair_display.sv
// swap_pair_display
//   Holds two BCD digits A and B and exchanges them on every level change of
//   the upstream `swap` toggle. Both digits drive active-high 7-segment
//   outputs, so the two-digit display alternates at the toggle rate.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous, active-low reset
//   swap      toggle from the swap-rate counter; each level change requests one exchange
//   load      single-cycle strobe capturing din_a / din_b
//   din_a     BCD digit loaded into A
//   din_b     BCD digit loaded into B
//   freeze    level; while high, exchange requests are discarded
//   seg_a     segments {g,f,e,d,c,b,a} for digit A
//   seg_b     segments {g,f,e,d,c,b,a} for digit B
//   swap_cnt  number of exchanges performed, wrapping
//   state     0=EMPTY, 1=RUN, 2=FROZEN
module swap_pair_display #(
    parameter int         CNT_W     = 8,
    parameter logic [6:0] BLANK_SEG = 7'b0000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             swap,
    input  logic             load,
    input  logic [3:0]       din_a,
    input  logic [3:0]       din_b,
    input  logic             freeze,
    output logic [6:0]       seg_a,
    output logic [6:0]       seg_b,
    output logic [CNT_W-1:0] swap_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       a_q, a_d;
    logic [3:0]       b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             swap_q;
    logic             primed;
    logic             swap_evt;

    // The upstream toggle may be X or arbitrary while in reset, so the very
    // first post-reset comparison against swap_q is masked by `primed`.
    assign swap_evt = primed & (swap ^ swap_q);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            swap_q <= 1'b0;
            primed <= 1'b0;
        end else begin
            swap_q <= swap;
            primed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
        end
    end

    // Priority within a cycle: load > freeze > exchange request.
    always_comb begin
        // NOTE: every output of this block is given a hold value first, so no
        // path through the case statement can infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;

        if (load) begin
            a_d     = din_a;
            b_d     = din_b;
            state_d = freeze ? ST_FROZEN : ST_RUN;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    // Nothing to exchange until data is loaded.
                end
                ST_RUN: begin
                    if (freeze) begin
                        state_d = ST_FROZEN;
                    end else if (swap_evt) begin
                        a_d   = b_q;
                        b_d   = a_q;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_FROZEN: begin
                    // Requests seen while frozen are dropped, not queued.
                    if (!freeze) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Digits 0-9 use the standard patterns; 10-15 show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    // Outputs are decoded straight from the registers, so an asynchronous
    // reset blanks the display without waiting for a clock edge.
    assign seg_a    = (state_q == ST_EMPTY) ? BLANK_SEG : seg_decode(a_q);
    assign seg_b    = (state_q == ST_EMPTY) ? BLANK_SEG : seg_decode(b_q);
    assign swap_cnt = cnt_q;
    assign state    = state_q;

endmodule

// File: tb/tb_swap_pair_display.sv
module tb_swap_pair_display;

    localparam logic [6:0] BLANK = 7'b0000000;
    localparam logic [6:0] S1    = 7'b0000110;
    localparam logic [6:0] S2    = 7'b1011011;
    localparam logic [6:0] S3    = 7'b1001111;
    localparam logic [6:0] S4    = 7'b1100110;
    localparam logic [6:0] S5    = 7'b1101101;
    localparam logic [6:0] S7    = 7'b0000111;
    localparam logic [6:0] S9    = 7'b1101111;
    localparam logic [6:0] DASH  = 7'b1000000;

    typedef struct {
        logic [1:0] st;
        logic [6:0] sa;
        logic [6:0] sb;
        logic [7:0] cnt;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       swap;
    logic       load;
    logic       freeze;
    logic [3:0] din_a;
    logic [3:0] din_b;
    logic [6:0] seg_a;
    logic [6:0] seg_b;
    logic [7:0] swap_cnt;
    logic [1:0] state;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    event chk_now;

    swap_pair_display #(
        .CNT_W(8),
        .BLANK_SEG(7'b0000000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .swap(swap),
        .load(load),
        .din_a(din_a),
        .din_b(din_b),
        .freeze(freeze),
        .seg_a(seg_a),
        .seg_b(seg_b),
        .swap_cnt(swap_cnt),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input exp_t e);
        checks++;
        if (state !== e.st || seg_a !== e.sa || seg_b !== e.sb || swap_cnt !== e.cnt) begin
            errors++;
            $display("FAIL %s: got state=%0d seg_a=%b seg_b=%b cnt=%0d, want state=%0d seg_a=%b seg_b=%b cnt=%0d",
                     e.name, state, seg_a, seg_b, swap_cnt, e.st, e.sa, e.sb, e.cnt);
        end
    endtask

    task automatic expect_now(input logic [1:0] es, input logic [6:0] ea, input logic [6:0] eb,
                              input logic [7:0] ec, input string nm);
        exp_t e;
        e.st   = es;
        e.sa   = ea;
        e.sb   = eb;
        e.cnt  = ec;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // One clock cycle of stimulus; the expected post-edge response is queued
    // for the monitor.
    task automatic cyc(input logic sw, input logic ld, input logic fr,
                       input logic [3:0] da, input logic [3:0] db,
                       input logic [1:0] es, input logic [6:0] ea, input logic [6:0] eb,
                       input logic [7:0] ec, input string nm);
        @(negedge clk);
        swap   = sw;
        load   = ld;
        freeze = fr;
        din_a  = da;
        din_b  = db;
        @(posedge clk);
        #1;
        expect_now(es, ea, eb, ec, nm);
    endtask

    // Monitor: compares on the falling edge, or immediately when stimulus
    // signals an asynchronous event.
    initial begin
        forever begin
            @(negedge clk or chk_now);
            while (exp_q.size() > 0) begin
                check(exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic sw_lvl;

        rst    = 1'b1;
        swap   = 1'b0;
        load   = 1'b0;
        freeze = 1'b0;
        din_a  = 4'd0;
        din_b  = 4'd0;
        #1;
        rst = 1'b0;

        // Reset then idle
        repeat (3) @(posedge clk);
        #1;
        expect_now(2'd0, BLANK, BLANK, 8'd0, "reset_state");
        ->chk_now;
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0, BLANK, BLANK, 8'd0, "idle_toggle1");
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0, BLANK, BLANK, 8'd0, "idle_toggle2");

        // Basic exchange
        cyc(1'b0, 1'b1, 1'b0, 4'd3, 4'd7, 2'd1, S3, S7, 8'd0, "load_3_7");
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 2'd1, S7, S3, 8'd1, "swap_rise");
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'd1, S3, S7, 8'd2, "swap_fall");
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 2'd1, S7, S3, 8'd3, "swap_consec");
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 2'd1, S7, S3, 8'd3, "swap_steady");

        // Freeze
        cyc(1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 2'd2, S7, S3, 8'd3, "freeze_enter");
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 2'd2, S7, S3, 8'd3, "frozen_tog1");
        cyc(1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 2'd2, S7, S3, 8'd3, "frozen_tog2");
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 2'd2, S7, S3, 8'd3, "frozen_tog3");
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'd1, S7, S3, 8'd3, "unfreeze");
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 2'd1, S3, S7, 8'd4, "swap_after_run");
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 2'd2, S3, S7, 8'd4, "freeze_beats_evt");
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'd1, S3, S7, 8'd4, "unfreeze2");

        // Load/event collision
        cyc(1'b1, 1'b1, 1'b0, 4'd1, 4'd2, 2'd1, S1, S2, 8'd4, "load_beats_evt");
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 2'd1, S1, S2, 8'd4, "after_collision");
        cyc(1'b1, 1'b1, 1'b1, 4'd4, 4'd5, 2'd2, S4, S5, 8'd4, "load_frozen");
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 2'd1, S4, S5, 8'd4, "run_after_load");

        // Wrap and invalid BCD: 256 exchanges bring the count back to its
        // starting value (4) passing 255 -> 0, digits end in place.
        cyc(1'b1, 1'b1, 1'b0, 4'd12, 4'd9, 2'd1, DASH, S9, 8'd4, "load_12_9");
        sw_lvl = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            sw_lvl = ~sw_lvl;
            cyc(sw_lvl, 1'b0, 1'b0, 4'd0, 4'd0, 2'd1,
                (i % 2 == 1) ? S9 : DASH,
                (i % 2 == 1) ? DASH : S9,
                8'((4 + i) % 256), $sformatf("wrap_%0d", i));
        end

        // Reset mid-run, asserted between clock edges, released with swap=1
        @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        expect_now(2'd0, BLANK, BLANK, 8'd0, "async_reset");
        ->chk_now;
        @(negedge clk);
        swap = 1'b1;
        rst  = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0, BLANK, BLANK, 8'd0, "post_reset_first");
        cyc(1'b1, 1'b1, 1'b0, 4'd3, 4'd7, 2'd1, S3, S7, 8'd0, "post_reset_load");
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 2'd1, S3, S7, 8'd0, "post_reset_hold");
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'd1, S7, S3, 8'd1, "post_reset_swap");

        // Drain the scoreboard within a bounded number of cycles.
        for (int n = 0; n < 20 && exp_q.size() > 0; n++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected responses never compared, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
